// File: rtl/modred_gl_pkg.sv
// Goldilocks field constants and pipeline record types shared by the multiplier,
// the modular reducer and the NTT butterfly.
package modred_gl_pkg;
    localparam int          GL_LOGQ   = 64;
    localparam int          GL_PROD_W = 2 * GL_LOGQ;
    localparam logic [63:0] GL_Q      = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] GL_EPS    = 64'h0000_0000_FFFF_FFFF;

    // Stage-1 record: partially reduced a-c plus the middle word still to fold in.
    typedef struct packed {
        logic [63:0] t0;
        logic [31:0] b;
    } st1_t;
endpackage

// File: rtl/modred_gl_addsub.sv
// Combinational 64-bit add/sub; a wrap past 2^64 is folded back using 2^64 == EPS mod Q.
// No state, no latency, no flow control.
module gl_addsub_eps
    import modred_gl_pkg::*;
(
    input  logic [63:0] x,
    input  logic [63:0] y,
    input  logic        sub,
    output logic [63:0] r
);
    logic [64:0] sum;
    logic [64:0] dif;

    assign sum = {1'b0, x} + {1'b0, y};
    assign dif = {1'b0, x} - {1'b0, y};

    // One fix-up is always enough for the operand ranges used by the reducer.
    assign r = sub ? (dif[64] ? dif[63:0] - GL_EPS : dif[63:0])
                   : (sum[64] ? sum[63:0] + GL_EPS : sum[63:0]);
endmodule

// File: rtl/modred_gl.sv
// Reduces a 128-bit product modulo Q = 2^64-2^32+1; 3-cycle latency, 1 result per cycle.
// Backpressure: one global enable stalls every stage in place; in_ready is that enable.
module modred_gl
    import modred_gl_pkg::*;
#(
    parameter int              LOGQ      = 64,
    parameter logic [LOGQ-1:0] Q         = 64'd18446744069414584321,
    parameter int              DELAY_RED = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [2*LOGQ-1:0] in_c,
    output logic              in_ready,
    output logic              out_valid,
    output logic [LOGQ-1:0]   out_r,
    input  logic              out_ready
);
    if (LOGQ != GL_LOGQ || 2 * LOGQ != GL_PROD_W || Q != GL_Q || DELAY_RED != 3) begin : g_bad_cfg
        $error("modred_gl: only LOGQ=64, Q=2^64-2^32+1, DELAY_RED=3 are supported");
    end

    logic        en;
    logic [63:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [63:0] t0_d;
    logic [63:0] t1;
    logic [63:0] t2_d;
    logic [63:0] r_d;

    st1_t        st1_q;
    logic        v1_q;
    logic [63:0] t2_q;
    logic        v2_q;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign a = in_c[63:0];
    assign b = in_c[95:64];
    assign c = in_c[127:96];

    // Stage 1: a - c, since 2^96 == -1 mod Q.
    gl_addsub_eps u_st1 (
        .x   (a),
        .y   ({32'd0, c}),
        .sub (1'b1),
        .r   (t0_d)
    );

    // Stage 2: b*(2^32-1) as a shift-subtract, added onto t0.
    assign t1 = {st1_q.b, 32'd0} - {32'd0, st1_q.b};

    gl_addsub_eps u_st2 (
        .x   (st1_q.t0),
        .y   (t1),
        .sub (1'b0),
        .r   (t2_d)
    );

    // Stage 3: t2 < 2^64 < 2Q, so a single conditional subtract lands in [0, Q-1].
    assign r_d = (t2_q >= Q) ? t2_q - Q : t2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st1_q     <= '0;
            v1_q      <= 1'b0;
            t2_q      <= '0;
            v2_q      <= 1'b0;
            out_r     <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            st1_q.t0  <= t0_d;
            st1_q.b   <= b;
            v1_q      <= in_valid;
            t2_q      <= t2_d;
            v2_q      <= v1_q;
            out_r     <= r_d;
            out_valid <= v2_q;
        end
    end
endmodule

// File: tb/tb_modred_gl.sv
// Bench for modred_gl: directed corner values, streaming, backpressure, reset flush and
// random traffic, all scored against a plain 128-bit "x mod Q" model.
module tb_modred_gl;
    localparam logic [127:0] Q128 = 128'd18446744069414584321;
    localparam logic [63:0]  Q64  = 64'hFFFF_FFFF_0000_0001;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_c;
    logic         in_ready;
    logic         out_valid;
    logic [63:0]  out_r;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    modred_gl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_c      (in_c),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_r     (out_r),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [127:0] x);
        logic [127:0] m;
        m = x % Q128;
        return m[63:0];
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'hFFFF_FFFE;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [127:0] rnd128();
        return {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_c = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_r !== 64'd0)    begin errors++; $display("FAIL reset_out_r got %h want 0", out_r); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %0b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    // Single items with an empty pipeline: value and exact 3-cycle latency.
    task automatic test_directed();
        logic [127:0] xs[8];
        logic [63:0]  es[8];
        logic [127:0] qm1;
        qm1   = Q128 - 128'd1;
        xs[0] = 128'd0;                               es[0] = 64'd0;
        xs[1] = Q128;                                 es[1] = 64'd0;
        xs[2] = 128'd1 << 64;                         es[2] = 64'h0000_0000_FFFF_FFFF;
        xs[3] = qm1 * qm1;                            es[3] = 64'd1;
        xs[4] = ~128'd0;                              es[4] = 64'hFFFF_FFFE_0000_0000;
        xs[5] = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0}; es[5] = 64'hFFFF_FFFD_0000_0002;
        xs[6] = Q128 + 128'd5;                        es[6] = 64'd5;
        xs[7] = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};     es[7] = 64'h0000_0000_FFFF_FFFE;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (model(xs[i]) !== es[i]) begin errors++; $display("FAIL model_%0d got %h want %h", i, model(xs[i]), es[i]); end
            in_c = xs[i]; in_valid = 1'b1;
            @(negedge clk);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_in_ready_%0d got %0b want 1", i, in_ready); end
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                if (k < 3) begin
                    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_early_%0d cycle %0d out_valid got %0b want 0", i, k, out_valid); end
                end else begin
                    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir_latency_%0d out_valid got %0b want 1", i, out_valid); end
                    checks++; if (out_r !== es[i])    begin errors++; $display("FAIL dir_value_%0d got %h want %h", i, out_r, es[i]); end
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] xs[16];
        int got;
        int first;
        got = 0; first = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (cyc < 16) begin
                xs[cyc] = rnd128(); in_c = xs[cyc]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                if (got >= 16) begin
                    checks++; errors++; $display("FAIL b2b_extra cycle %0d got %h want none", cyc, out_r);
                end else begin
                    checks++; if (out_r !== model(xs[got])) begin errors++; $display("FAIL b2b_value_%0d got %h want %h", got, out_r, model(xs[got])); end
                    if (first < 0) first = cyc;
                    else begin
                        checks++; if (cyc != first + got) begin errors++; $display("FAIL b2b_gap_%0d cycle %0d want %0d", got, cyc, first + got); end
                    end
                    got++;
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (got != 16)  begin errors++; $display("FAIL b2b_count got %0d want 16", got); end
        checks++; if (first != 3) begin errors++; $display("FAIL b2b_first_cycle got %0d want 3", first); end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_q[$];
        logic [63:0] e;
        logic [63:0] first_r;
        logic        acc;
        int sent;
        int got;
        sent = 0; got = 0; first_r = '0;
        out_ready = 1'b0; in_valid = 1'b1; in_c = rnd128();
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (cyc >= 3 && cyc <= 7) begin
                checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall cycle %0d in_ready %0b out_valid %0b want 0 1", cyc, in_ready, out_valid); end
                if (cyc == 3) first_r = out_r;
                else begin
                    checks++; if (out_r !== first_r) begin errors++; $display("FAIL bp_stable cycle %0d got %h want %h", cyc, out_r, first_r); end
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL bp_extra got %h want none", out_r);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if (out_r !== e) begin errors++; $display("FAIL bp_value_%0d got %h want %h", got, out_r, e); end
                    got++;
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin exp_q.push_back(model(in_c)); sent++; end
            @(posedge clk); #1;
            if (acc) begin
                if (sent < 5) in_c = rnd128();
                else          in_valid = 1'b0;
            end
            out_ready = (cyc + 1 >= 8);
        end
        checks++; if (got != 5 || sent != 5) begin errors++; $display("FAIL bp_count got %0d sent %0d want 5 5", got, sent); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_c = rnd128(); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_inflight got %0b want 1", out_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flush got %0b want 0", out_valid); end
        checks++; if (out_r !== 64'd0)    begin errors++; $display("FAIL rstmid_out_r got %h want 0", out_r); end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale cycle %0d got %0b want 0", k, out_valid); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int n_cycles);
        logic [63:0] exp_q[$];
        logic [63:0] e;
        logic [63:0] held_r;
        logic        stalled;
        logic        acc;
        stalled = 1'b0; held_r = '0; acc = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < n_cycles + 8; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                checks++; if (out_valid !== 1'b1 || out_r !== held_r) begin errors++; $display("FAIL rnd_hold cycle %0d got %0b %h want 1 %h", cyc, out_valid, out_r, held_r); end
            end
            checks++; if (in_ready !== (!out_valid || out_ready)) begin errors++; $display("FAIL rnd_in_ready cycle %0d got %0b want %0b", cyc, in_ready, !out_valid || out_ready); end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL rnd_extra cycle %0d got %h want none", cyc, out_r);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if (out_r !== e)  begin errors++; $display("FAIL rnd_value cycle %0d got %h want %h", cyc, out_r, e); end
                    checks++; if (out_r >= Q64) begin errors++; $display("FAIL rnd_range cycle %0d got %h want below %h", cyc, out_r, Q64); end
                end
            end
            stalled = out_valid && !out_ready;
            held_r  = out_r;
            acc     = in_valid && in_ready;
            if (acc) exp_q.push_back(model(in_c));
            @(posedge clk); #1;
            if (cyc >= n_cycles) begin
                in_valid = 1'b0; out_ready = 1'b1;
            end else begin
                if (!in_valid || acc) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_c     = rnd128();
                end
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_lost got %0d pending want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random(20000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
